// File: rtl/mcu_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// The j instruction path exists only when MCU_JUMP_EN is defined.
package mcu_pkg;

  localparam int OPCODE_W = 6;
  localparam int ALUOP_W  = 2;
  localparam int CNT_W    = 16;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
`ifdef MCU_JUMP_EN
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`else
    S_ADDIWB = 4'd10
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational state -> control-word decode; reset forces the whole word to zero.
// JUMP decoding is present only when MCU_JUMP_EN is defined.
module mcu_output_decode
  import mcu_pkg::*;
(
  input  logic   reset_i,
  input  state_t state_i,
  input  logic   mem_ready_i,
  input  logic   illegal_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (!reset_i) begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = SRCB_FOUR;
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.pc_source = PCS_ALU;
          // IR and PC advance only on the cycle memory actually returns the word
          ctrl_o.ir_write  = mem_ready_i;
          ctrl_o.pc_write  = mem_ready_i;
        end
        S_DECODE: begin
          ctrl_o.alu_src_b = SRCB_IMMSH;
          ctrl_o.illegal   = illegal_i;
        end
        S_MEMADR, S_ADDIEX: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.mem_reg   = 1'b1;
        end
        S_MEMWR: begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_RT;
          ctrl_o.alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl_o.alu_src_a     = 1'b1;
          ctrl_o.alu_src_b     = SRCB_RT;
          ctrl_o.alu_op        = ALU_SUB;
          ctrl_o.pc_write_cond = 1'b1;
          ctrl_o.pc_source     = PCS_ALUOUT;
        end
        S_ADDIWB: ctrl_o.reg_write = 1'b1;
`ifdef MCU_JUMP_EN
        S_JUMP: begin
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PCS_JUMP;
        end
`endif
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with memory wait states, illegal-opcode pulse and retire counter.
// Define MCU_JUMP_EN to support the j instruction; otherwise j decodes as illegal.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Instruction,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic                Illegal,
  output logic [CNT_W-1:0]    InstrCount
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              is_sw_q, is_sw_d;
  logic              retire;
  logic              illegal_op;
  ctrl_t             ctrl;

  always_comb begin
    state_d    = S_FETCH;
    retire     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Instruction)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MCU_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      illegal_op = 1'b1;
        endcase
      end
      // load/store choice comes from the opcode latched in DECODE, not the live input
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  retire = 1'b1;
      S_MEMWR: begin
        if (MemReady) retire = 1'b1;
        else          state_d = S_MEMWR;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  retire = 1'b1;
      S_BRANCH: retire = 1'b1;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: retire = 1'b1;
`ifdef MCU_JUMP_EN
      S_JUMP:   retire = 1'b1;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  assign is_sw_d = (state_q == S_DECODE) ? (Instruction == OP_SW) : is_sw_q;
  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      is_sw_q <= is_sw_d;
    end
  end

  mcu_output_decode u_decode (
    .reset_i     (reset),
    .state_i     (state_q),
    .mem_ready_i (MemReady),
    .illegal_i   (illegal_op),
    .ctrl_o      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemReg      = ctrl.mem_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ALUOP_W'(ctrl.alu_op);
  assign PCSource    = ctrl.pc_source;
  assign Illegal     = ctrl.illegal;
  assign InstrCount  = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: each instruction is expanded into its expected cycle-by-cycle phase list;
// one negedge process compares every DUT output against the phase table. Honours MCU_JUMP_EN.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Instruction;
  logic        MemReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemReg, RegDst, RegWrite, ALUSrcA, Illegal;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [15:0] InstrCount;

  multicycle_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .Instruction (Instruction),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemReg      (MemReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .Illegal     (Illegal),
    .InstrCount  (InstrCount)
  );

  always #5 clk = ~clk;

  localparam int P_RESET = 0,  P_FETCH = 1,  P_DEC = 2,   P_DEC_ILL = 3, P_MADR = 4;
  localparam int P_MRD   = 5,  P_MWB   = 6,  P_MWR = 7,   P_EXEC = 8,    P_AWB = 9;
  localparam int P_BR    = 10, P_IEX   = 11, P_IWB = 12,  P_JMP = 13;

  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_en = 1'b0;
  int          exp_ph = P_RESET;
  logic [15:0] exp_cnt = 16'd0;

  // Field order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemReg RegDst RegWrite
  //              ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] Illegal
  function automatic logic [16:0] ph_word(input int ph, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, mreg, rdst, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, mreg, rdst, rw, asa, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (ph)
      P_FETCH:   begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      P_DEC:     asb = 2'b11;
      P_DEC_ILL: begin asb = 2'b11; ill = 1; end
      P_MADR:    begin asa = 1; asb = 2'b10; end
      P_MRD:     begin mrd = 1; iord = 1; end
      P_MWB:     begin rw = 1; mreg = 1; end
      P_MWR:     begin mwr = 1; iord = 1; end
      P_EXEC:    begin asa = 1; aop = 2'b10; end
      P_AWB:     begin rw = 1; rdst = 1; end
      P_BR:      begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      P_IEX:     begin asa = 1; asb = 2'b10; end
      P_IWB:     rw = 1;
      P_JMP:     begin pcw = 1; pcs = 2'b10; end
      default:   ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, mreg, rdst, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic bit retires(input int ph, input logic mr);
    return (ph == P_MWB) || (ph == P_AWB) || (ph == P_BR) || (ph == P_IWB) ||
           (ph == P_JMP) || ((ph == P_MWR) && mr);
  endfunction

  wire [16:0] dut_word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemReg,
                          RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (dut_word !== ph_word(exp_ph, MemReady)) begin
        miscompares++;
        $display("FAIL ctrl phase=%0d t=%0t got=%b want=%b", exp_ph, $time, dut_word,
                 ph_word(exp_ph, MemReady));
      end
      vectors++;
      if (InstrCount !== exp_cnt) begin
        miscompares++;
        $display("FAIL count phase=%0d t=%0t got=%0d want=%0d", exp_ph, $time, InstrCount, exp_cnt);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One clock of stimulus: opcode given only matters in DECODE, elsewhere pass junk.
  task automatic step(input int ph, input logic mr, input logic [5:0] op);
    exp_ph      = ph;
    MemReady    = mr;
    Instruction = op;
    chk_en      = 1'b1;
    @(posedge clk);
    #1;
    if (retires(ph, mr)) exp_cnt = exp_cnt + 16'd1;
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic do_instr(input logic [5:0] op, input int fetch_waits, input int mem_waits);
    for (int i = 0; i < fetch_waits; i++) step(P_FETCH, 1'b0, junk());
    step(P_FETCH, 1'b1, junk());
    case (op)
      6'b100011: begin
        step(P_DEC, 1'($urandom_range(0, 1)), op);
        step(P_MADR, 1'b1, junk());
        for (int i = 0; i < mem_waits; i++) step(P_MRD, 1'b0, junk());
        step(P_MRD, 1'b1, junk());
        step(P_MWB, 1'b1, junk());
      end
      6'b101011: begin
        step(P_DEC, 1'b1, op);
        step(P_MADR, 1'b1, 6'b100011);
        for (int i = 0; i < mem_waits; i++) step(P_MWR, 1'b0, junk());
        step(P_MWR, 1'b1, junk());
      end
      6'b000000: begin step(P_DEC, 1'b0, op); step(P_EXEC, 1'b1, junk()); step(P_AWB, 1'b1, junk()); end
      6'b000100: begin step(P_DEC, 1'b1, op); step(P_BR, 1'b1, junk()); end
      6'b001000: begin step(P_DEC, 1'b1, op); step(P_IEX, 1'b1, junk()); step(P_IWB, 1'b0, junk()); end
`ifdef MCU_JUMP_EN
      6'b000010: begin step(P_DEC, 1'b1, op); step(P_JMP, 1'b1, junk()); end
`endif
      default:   step(P_DEC_ILL, 1'b1, op);
    endcase
    $display("instr op=%b fetch_waits=%0d mem_waits=%0d count=%0d", op, fetch_waits, mem_waits,
             InstrCount);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; MemReady = 1'b1; Instruction = 6'b100011;
    // model pin: FETCH with memory ready
    check_lit("fetch_word_model", 32'(ph_word(P_FETCH, 1'b1)), 32'(17'b1001010000_01_00_00_0));
    @(posedge clk); #1;
    step(P_RESET, 1'b1, 6'b100011);
    step(P_RESET, 1'b1, 6'b000000);
    reset = 1'b0;
    step(P_FETCH, 1'b0, junk());   // stalled fetch: no IR/PC write
    // same cycle as next FETCH check below, literal pin on IRWrite/PCWrite
    MemReady = 1'b1; #1;
    check_lit("fetch_irwrite", 32'(IRWrite), 32'd1);
    check_lit("fetch_pcwrite", 32'(PCWrite), 32'd1);
    $display("reset released count=%0d", InstrCount);

    // lw with zero wait states (FETCH continues from the cycle above)
    exp_ph = P_FETCH;
    @(posedge clk); #1;
    step(P_DEC, 1'b1, 6'b100011);
    step(P_MADR, 1'b1, junk());
    step(P_MRD, 1'b1, junk());
    step(P_MWB, 1'b1, junk());
    check_lit("lw_count", 32'(InstrCount), 32'd1);
    $display("instr op=100011 fetch_waits=0 mem_waits=0 count=%0d", InstrCount);

    do_instr(6'b101011, 1, 3);       // sw with 3-cycle wait
    check_lit("sw_count", 32'(InstrCount), 32'd2);
    do_instr(6'b100011, 2, 2);       // lw with waits in fetch and memory
    do_instr(6'b000000, 0, 0);
    do_instr(6'b000100, 0, 0);
    check_lit("r_beq_count", 32'(InstrCount), 32'd5);
    do_instr(6'b111111, 0, 0);
    check_lit("illegal_count", 32'(InstrCount), 32'd5);
    do_instr(6'b000010, 0, 0);
`ifdef MCU_JUMP_EN
    check_lit("j_count", 32'(InstrCount), 32'd6);
`else
    check_lit("j_count", 32'(InstrCount), 32'd5);
`endif
    do_instr(6'b001000, 0, 0);

    // counter wrap
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    exp_cnt = 16'hFFFF;
    do_instr(6'b001000, 0, 0);
    check_lit("wrap_count", 32'(InstrCount), 32'd0);

    // reset during a stalled load
    step(P_FETCH, 1'b1, junk());
    step(P_DEC, 1'b1, 6'b100011);
    step(P_MADR, 1'b1, junk());
    step(P_MRD, 1'b0, junk());
    reset = 1'b1; #1;
    check_lit("reset_memread", 32'(MemRead), 32'd0);
    exp_cnt = 16'd0;
    step(P_RESET, 1'b0, junk());
    reset = 1'b0;
    $display("reset mid-load count=%0d", InstrCount);
    do_instr(6'b000000, 0, 0);
    check_lit("post_reset_count", 32'(InstrCount), 32'd1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
